alu_issue_scheduler: RTL and testbench

- Reservation station and issue controller for the single integer ALU.
- Buffers decoded ALU/branch micro-ops from dispatch and tracks operand readiness by snooping both CDB sources (ALU result, LSB result).
- Each cycle it selects one ready entry round-robin and drives the ALU request interface with a registered one-cycle pulse.
- Sits between dispatch/decoder and arith_logic_unit; flushed on branch misprediction by the ROB.

---
 rtl/alu_issue_scheduler_pkg.sv | 68 ++++++
 rtl/alu_issue_scheduler_rr_ready_picker.sv | 26 ++
 rtl/alu_issue_scheduler.sv | 146 ++++++++++++++
 tb/tb_alu_issue_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_scheduler_pkg.sv
// Shared widths, opcodes and payload types for the ALU reservation station.
package alu_issue_scheduler_pkg;

    localparam int unsigned OP_W      = 6;
    localparam int unsigned ROB_BIT   = 4;
    localparam int unsigned DAT_W     = 32;
    localparam int unsigned RAM_ADR_W = 17;

    // RS_SIZE must stay a power of two so the pointer wraps by truncation.
    localparam int unsigned RS_SIZE   = 8;
    localparam int unsigned RS_BIT    = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd2;
    localparam logic [OP_W-1:0] OP_AND  = 6'd3;
    localparam logic [OP_W-1:0] OP_OR   = 6'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 6'd5;
    localparam logic [OP_W-1:0] OP_SLL  = 6'd6;
    localparam logic [OP_W-1:0] OP_SRL  = 6'd7;
    localparam logic [OP_W-1:0] OP_SRA  = 6'd8;
    localparam logic [OP_W-1:0] OP_SLT  = 6'd9;
    localparam logic [OP_W-1:0] OP_SLTU = 6'd10;
    localparam logic [OP_W-1:0] OP_ADDI = 6'd11;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'd20;
    localparam logic [OP_W-1:0] OP_BNE  = 6'd21;
    localparam logic [OP_W-1:0] OP_JAL  = 6'd30;
    localparam logic [OP_W-1:0] OP_JALR = 6'd31;

    typedef struct packed {
        logic               busy;
        logic [ROB_BIT-1:0] tag;
        logic [DAT_W-1:0]   val;
    } operand_t;

    typedef struct packed {
        logic               en;
        logic [ROB_BIT-1:0] q;
        logic [DAT_W-1:0]   v;
    } cdb_t;

    typedef struct packed {
        logic [OP_W-1:0]      op;
        logic                 ic;
        logic [ROB_BIT-1:0]   qd;
        operand_t             s;
        operand_t             t;
        logic [DAT_W-1:0]     imm;
        logic [RAM_ADR_W-1:0] pc;
    } rs_entry_t;

    // Resolve a pending operand against both broadcasts; ALU result takes priority.
    function automatic operand_t snoop(input operand_t o, input cdb_t alu, input cdb_t lsb);
        operand_t r;
        r = o;
        if (o.busy) begin
            if (alu.en && alu.q == o.tag) begin
                r.busy = 1'b0;
                r.val  = alu.v;
            end else if (lsb.en && lsb.q == o.tag) begin
                r.busy = 1'b0;
                r.val  = lsb.v;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_scheduler_rr_ready_picker.sv
// Round-robin priority encoder: first ready slot after ptr, wrapping.
module rr_ready_picker
    import alu_issue_scheduler_pkg::*;
(
    input  logic [RS_SIZE-1:0] ready,
    input  logic [RS_BIT-1:0]  ptr,
    output logic               found,
    output logic [RS_BIT-1:0]  index
);

    logic [RS_BIT-1:0] idx;

    always_comb begin
        found = 1'b0;
        index = '0;
        idx   = '0;
        for (int k = 1; k <= int'(RS_SIZE); k++) begin
            idx = ptr + RS_BIT'(k);
            if (!found && ready[idx]) begin
                found = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Reservation station for the integer ALU: buffers dispatched ops, snoops both
// CDBs for operands and issues one ready entry per cycle round-robin.
module alu_issue_scheduler
    import alu_issue_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush_i,

    input  logic                 dp_en_i,
    input  logic [OP_W-1:0]      dp_op_i,
    input  logic                 dp_ic_i,
    input  logic [ROB_BIT-1:0]   dp_qd_i,
    input  logic                 dp_sbusy_i,
    input  logic [ROB_BIT-1:0]   dp_qs_i,
    input  logic [DAT_W-1:0]     dp_vs_i,
    input  logic                 dp_tbusy_i,
    input  logic [ROB_BIT-1:0]   dp_qt_i,
    input  logic [DAT_W-1:0]     dp_vt_i,
    input  logic [DAT_W-1:0]     dp_imm_i,
    input  logic [RAM_ADR_W-1:0] dp_pc_i,
    output logic                 full_o,

    input  logic                 cdb_alu_en_i,
    input  logic [ROB_BIT-1:0]   cdb_alu_q_i,
    input  logic [DAT_W-1:0]     cdb_alu_v_i,
    input  logic                 cdb_lsb_en_i,
    input  logic [ROB_BIT-1:0]   cdb_lsb_q_i,
    input  logic [DAT_W-1:0]     cdb_lsb_v_i,

    output logic                 alu_en_o,
    output logic [OP_W-1:0]      alu_op_o,
    output logic                 alu_ic_o,
    output logic [ROB_BIT-1:0]   alu_qd_o,
    output logic [DAT_W-1:0]     alu_vs_o,
    output logic [DAT_W-1:0]     alu_vt_o,
    output logic [DAT_W-1:0]     alu_imm_o,
    output logic [RAM_ADR_W-1:0] alu_pc_o
);

    rs_entry_t          entry [RS_SIZE];
    logic [RS_SIZE-1:0] valid;
    logic [RS_SIZE-1:0] ready;
    logic [RS_BIT-1:0]  rr_ptr;
    logic [RS_BIT-1:0]  pick_idx;
    logic               pick_found;
    logic [RS_BIT-1:0]  free_idx;
    logic               free_found;
    logic               full;
    cdb_t               cdb_alu;
    cdb_t               cdb_lsb;
    rs_entry_t          dp_entry;

    assign cdb_alu = '{en: cdb_alu_en_i, q: cdb_alu_q_i, v: cdb_alu_v_i};
    assign cdb_lsb = '{en: cdb_lsb_en_i, q: cdb_lsb_q_i, v: cdb_lsb_v_i};

    assign full   = &valid;
    assign full_o = full;

    // Readiness comes only from registered state; same-edge wakeups count next cycle.
    always_comb begin
        ready = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            ready[i] = valid[i] & ~entry[i].s.busy & ~entry[i].t.busy;
        end
    end

    // Lowest-index free slot for dispatch.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (!free_found && !valid[i]) begin
                free_found = 1'b1;
                free_idx   = RS_BIT'(i);
            end
        end
    end

    // Incoming op with operands bypassed from any same-cycle broadcast.
    always_comb begin
        dp_entry     = '0;
        dp_entry.op  = dp_op_i;
        dp_entry.ic  = dp_ic_i;
        dp_entry.qd  = dp_qd_i;
        dp_entry.s   = snoop('{busy: dp_sbusy_i, tag: dp_qs_i, val: dp_vs_i}, cdb_alu, cdb_lsb);
        dp_entry.t   = snoop('{busy: dp_tbusy_i, tag: dp_qt_i, val: dp_vt_i}, cdb_alu, cdb_lsb);
        dp_entry.imm = dp_imm_i;
        dp_entry.pc  = dp_pc_i;
    end

    rr_ready_picker u_picker (
        .ready (ready),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            rr_ptr    <= '0;
            alu_en_o  <= 1'b0;
            alu_op_o  <= '0;
            alu_ic_o  <= 1'b0;
            alu_qd_o  <= '0;
            alu_vs_o  <= '0;
            alu_vt_o  <= '0;
            alu_imm_o <= '0;
            alu_pc_o  <= '0;
        end else if (en) begin
            if (flush_i) begin
                valid    <= '0;
                alu_en_o <= 1'b0;
            end else begin
                for (int i = 0; i < int'(RS_SIZE); i++) begin
                    entry[i].s <= snoop(entry[i].s, cdb_alu, cdb_lsb);
                    entry[i].t <= snoop(entry[i].t, cdb_alu, cdb_lsb);
                end

                if (pick_found) begin
                    alu_en_o        <= 1'b1;
                    alu_op_o        <= entry[pick_idx].op;
                    alu_ic_o        <= entry[pick_idx].ic;
                    alu_qd_o        <= entry[pick_idx].qd;
                    alu_vs_o        <= entry[pick_idx].s.val;
                    alu_vt_o        <= entry[pick_idx].t.val;
                    alu_imm_o       <= entry[pick_idx].imm;
                    alu_pc_o        <= entry[pick_idx].pc;
                    valid[pick_idx] <= 1'b0;
                    rr_ptr          <= pick_idx;
                end else begin
                    alu_en_o <= 1'b0;
                end

                // Free slot is invalid at cycle start, so it never collides with the issued slot.
                if (dp_en_i && !full && free_found) begin
                    entry[free_idx] <= dp_entry;
                    valid[free_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler: issue latency, wakeup, bypass,
// full/round-robin order, flush, freeze and reset.
module tb_alu_issue_scheduler;
    import alu_issue_scheduler_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic                 flush_i;
    logic                 dp_en_i;
    logic [OP_W-1:0]      dp_op_i;
    logic                 dp_ic_i;
    logic [ROB_BIT-1:0]   dp_qd_i;
    logic                 dp_sbusy_i;
    logic [ROB_BIT-1:0]   dp_qs_i;
    logic [DAT_W-1:0]     dp_vs_i;
    logic                 dp_tbusy_i;
    logic [ROB_BIT-1:0]   dp_qt_i;
    logic [DAT_W-1:0]     dp_vt_i;
    logic [DAT_W-1:0]     dp_imm_i;
    logic [RAM_ADR_W-1:0] dp_pc_i;
    logic                 full_o;
    logic                 cdb_alu_en_i;
    logic [ROB_BIT-1:0]   cdb_alu_q_i;
    logic [DAT_W-1:0]     cdb_alu_v_i;
    logic                 cdb_lsb_en_i;
    logic [ROB_BIT-1:0]   cdb_lsb_q_i;
    logic [DAT_W-1:0]     cdb_lsb_v_i;
    logic                 alu_en_o;
    logic [OP_W-1:0]      alu_op_o;
    logic                 alu_ic_o;
    logic [ROB_BIT-1:0]   alu_qd_o;
    logic [DAT_W-1:0]     alu_vs_o;
    logic [DAT_W-1:0]     alu_vt_o;
    logic [DAT_W-1:0]     alu_imm_o;
    logic [RAM_ADR_W-1:0] alu_pc_o;

    int total;
    int bad;

    alu_issue_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .flush_i      (flush_i),
        .dp_en_i      (dp_en_i),
        .dp_op_i      (dp_op_i),
        .dp_ic_i      (dp_ic_i),
        .dp_qd_i      (dp_qd_i),
        .dp_sbusy_i   (dp_sbusy_i),
        .dp_qs_i      (dp_qs_i),
        .dp_vs_i      (dp_vs_i),
        .dp_tbusy_i   (dp_tbusy_i),
        .dp_qt_i      (dp_qt_i),
        .dp_vt_i      (dp_vt_i),
        .dp_imm_i     (dp_imm_i),
        .dp_pc_i      (dp_pc_i),
        .full_o       (full_o),
        .cdb_alu_en_i (cdb_alu_en_i),
        .cdb_alu_q_i  (cdb_alu_q_i),
        .cdb_alu_v_i  (cdb_alu_v_i),
        .cdb_lsb_en_i (cdb_lsb_en_i),
        .cdb_lsb_q_i  (cdb_lsb_q_i),
        .cdb_lsb_v_i  (cdb_lsb_v_i),
        .alu_en_o     (alu_en_o),
        .alu_op_o     (alu_op_o),
        .alu_ic_o     (alu_ic_o),
        .alu_qd_o     (alu_qd_o),
        .alu_vs_o     (alu_vs_o),
        .alu_vt_o     (alu_vt_o),
        .alu_imm_o    (alu_imm_o),
        .alu_pc_o     (alu_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush_i      = 1'b0;
        dp_en_i      = 1'b0;
        dp_op_i      = '0;
        dp_ic_i      = 1'b0;
        dp_qd_i      = '0;
        dp_sbusy_i   = 1'b0;
        dp_qs_i      = '0;
        dp_vs_i      = '0;
        dp_tbusy_i   = 1'b0;
        dp_qt_i      = '0;
        dp_vt_i      = '0;
        dp_imm_i     = '0;
        dp_pc_i      = '0;
        cdb_alu_en_i = 1'b0;
        cdb_alu_q_i  = '0;
        cdb_alu_v_i  = '0;
        cdb_lsb_en_i = 1'b0;
        cdb_lsb_q_i  = '0;
        cdb_lsb_v_i  = '0;
    endtask

    task automatic dp_set(input logic [OP_W-1:0] op, input logic [ROB_BIT-1:0] qd,
                          input logic sb, input logic [ROB_BIT-1:0] qs, input logic [DAT_W-1:0] vs,
                          input logic tb, input logic [ROB_BIT-1:0] qt, input logic [DAT_W-1:0] vt,
                          input logic [DAT_W-1:0] imm, input logic [RAM_ADR_W-1:0] pc);
        dp_en_i    = 1'b1;
        dp_op_i    = op;
        dp_ic_i    = 1'b0;
        dp_qd_i    = qd;
        dp_sbusy_i = sb;
        dp_qs_i    = qs;
        dp_vs_i    = vs;
        dp_tbusy_i = tb;
        dp_qt_i    = qt;
        dp_vt_i    = vt;
        dp_imm_i   = imm;
        dp_pc_i    = pc;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        en    = 1'b1;
        rst   = 1'b1;
        clear_inputs();
        tick();
        tick();
        chk("rst_alu_en", 64'(alu_en_o), 64'd0);
        chk("rst_qd", 64'(alu_qd_o), 64'd0);
        chk("rst_full", 64'(full_o), 64'd0);
        rst = 1'b0;

        // Ready ADDI: written at the first edge, issued at the next.
        dp_set(OP_ADDI, 4'd2, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0, 32'd3, 17'h100);
        tick();
        chk("addi_not_yet", 64'(alu_en_o), 64'd0);
        clear_inputs();
        tick();
        chk("addi_en", 64'(alu_en_o), 64'd1);
        chk("addi_qd", 64'(alu_qd_o), 64'd2);
        chk("addi_vs", 64'(alu_vs_o), 64'd5);
        chk("addi_imm", 64'(alu_imm_o), 64'd3);
        chk("addi_op", 64'(alu_op_o), 64'(OP_ADDI));
        chk("addi_pc", 64'(alu_pc_o), 64'h100);
        chk("addi_full", 64'(full_o), 64'd0);
        tick();
        chk("addi_pulse_end", 64'(alu_en_o), 64'd0);
        chk("addi_qd_hold", 64'(alu_qd_o), 64'd2);

        // ADD waiting on rs1 tag 4, woken by the LSB broadcast.
        dp_set(OP_ADD, 4'd3, 1'b1, 4'd4, 32'd0, 1'b0, 4'd0, 32'd1, 32'd0, 17'h104);
        tick();
        clear_inputs();
        tick();
        chk("wait_c1", 64'(alu_en_o), 64'd0);
        tick();
        chk("wait_c2", 64'(alu_en_o), 64'd0);
        cdb_lsb_en_i = 1'b1;
        cdb_lsb_q_i  = 4'd4;
        cdb_lsb_v_i  = 32'h10;
        tick();
        chk("wake_same_edge", 64'(alu_en_o), 64'd0);
        clear_inputs();
        tick();
        chk("wake_en", 64'(alu_en_o), 64'd1);
        chk("wake_qd", 64'(alu_qd_o), 64'd3);
        chk("wake_vs", 64'(alu_vs_o), 64'h10);
        chk("wake_vt", 64'(alu_vt_o), 64'd1);

        // rs2 tag 7 broadcast by the ALU in the dispatch cycle itself.
        dp_set(OP_SUB, 4'd5, 1'b0, 4'd0, 32'd2, 1'b1, 4'd7, 32'd0, 32'd0, 17'h108);
        cdb_alu_en_i = 1'b1;
        cdb_alu_q_i  = 4'd7;
        cdb_alu_v_i  = 32'd9;
        tick();
        chk("byp_first", 64'(alu_en_o), 64'd0);
        clear_inputs();
        tick();
        chk("byp_en", 64'(alu_en_o), 64'd1);
        chk("byp_qd", 64'(alu_qd_o), 64'd5);
        chk("byp_vt", 64'(alu_vt_o), 64'd9);

        // Fill all slots with ops held on tag 9; pointer sits at 0 so order is 1..7,0.
        for (int i = 0; i < 8; i++) begin
            dp_set(OP_ADD, ROB_BIT'(i), 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'(i), 32'd0, 17'h200);
            tick();
        end
        chk("fill_full", 64'(full_o), 64'd1);
        dp_set(OP_ADDI, 4'd8, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0, 17'h300);
        tick();
        chk("ninth_full", 64'(full_o), 64'd1);
        chk("ninth_no_issue", 64'(alu_en_o), 64'd0);
        clear_inputs();
        cdb_alu_en_i = 1'b1;
        cdb_alu_q_i  = 4'd9;
        cdb_alu_v_i  = 32'h55;
        tick();
        chk("fill_wake", 64'(alu_en_o), 64'd0);
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_en", 64'(alu_en_o), 64'd1);
            chk("rr_qd", 64'(alu_qd_o), 64'((i + 1) % 8));
            chk("rr_vs", 64'(alu_vs_o), 64'h55);
            if (i == 0) chk("rr_full_drop", 64'(full_o), 64'd0);
        end
        tick();
        chk("ninth_lost", 64'(alu_en_o), 64'd0);

        // Three pending entries, then flush together with a ready dispatch.
        for (int i = 0; i < 3; i++) begin
            dp_set(OP_ADD, ROB_BIT'(i + 1), 1'b1, 4'd10, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 17'h400);
            tick();
        end
        dp_set(OP_ADDI, 4'd6, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 17'h404);
        flush_i = 1'b1;
        tick();
        chk("flush_full", 64'(full_o), 64'd0);
        chk("flush_en", 64'(alu_en_o), 64'd0);
        clear_inputs();
        tick();
        chk("flush_dp_lost", 64'(alu_en_o), 64'd0);
        cdb_alu_en_i = 1'b1;
        cdb_alu_q_i  = 4'd10;
        cdb_alu_v_i  = 32'd1;
        tick();
        clear_inputs();
        tick();
        chk("flush_pending_lost", 64'(alu_en_o), 64'd0);

        // Dispatch and issue at one edge, then freeze with en low.
        dp_set(OP_ADDI, 4'd1, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'd0, 32'd0, 17'h500);
        tick();
        dp_set(OP_ADD, 4'd6, 1'b0, 4'd0, 32'h77, 1'b0, 4'd0, 32'd0, 32'd0, 17'h504);
        tick();
        chk("pre_freeze_en", 64'(alu_en_o), 64'd1);
        chk("pre_freeze_qd", 64'(alu_qd_o), 64'd1);
        clear_inputs();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frozen_en", 64'(alu_en_o), 64'd1);
            chk("frozen_qd", 64'(alu_qd_o), 64'd1);
        end
        en = 1'b1;
        tick();
        chk("thaw_en", 64'(alu_en_o), 64'd1);
        chk("thaw_qd", 64'(alu_qd_o), 64'd6);
        chk("thaw_vs", 64'(alu_vs_o), 64'h77);

        // Synchronous reset mid-stream.
        dp_set(OP_ADD, 4'd4, 1'b0, 4'd0, 32'h44, 1'b0, 4'd0, 32'd0, 32'd0, 17'h600);
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        chk("mid_rst_en", 64'(alu_en_o), 64'd0);
        chk("mid_rst_qd", 64'(alu_qd_o), 64'd0);
        chk("mid_rst_vs", 64'(alu_vs_o), 64'd0);
        chk("mid_rst_full", 64'(full_o), 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 64'(alu_en_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
